// File: rtl/vga_timing_ctrl_param.sv
// rtl/vga_timing_ctrl_param.sv - parametrised VGA/DVI raster timing generator with aligned colour output
// Optional: define VGA_TEST_PATTERN_EN for a tp_sel input selecting built-in 8-bar colour pattern.
module vga_timing_ctrl_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10,
  parameter int COLOR_W  = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               tp_sel,
`endif
  input  logic [COLOR_W-1:0] i_red,
  input  logic [COLOR_W-1:0] i_green,
  input  logic [COLOR_W-1:0] i_blue,
  output logic [CNT_W-1:0]   px,
  output logic [CNT_W-1:0]   py,
  output logic               req,
  output logic               frame_start,
  output logic               line_start,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_h_sync,
  output logic               vga_v_sync,
  output logic               vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // One extra bit so sync-end bounds equal to 2**CNT_W still compare correctly
  localparam logic [CNT_W:0] H_ACT_X = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_X = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_BEG  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HP = 1'(H_POL);
  localparam logic VP = 1'(V_POL);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             hs_raw;
  logic             vs_raw;
  logic             de_raw;

  logic hs_pipe [PIPE_LAT];
  logic vs_pipe [PIPE_LAT];
  logic de_pipe [PIPE_LAT];

  logic [COLOR_W-1:0] r_nxt;
  logic [COLOR_W-1:0] g_nxt;
  logic [COLOR_W-1:0] b_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    hs_raw      = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
    vs_raw      = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
    de_raw      = ({1'b0, h_cnt} < H_ACT_X) && ({1'b0, v_cnt} < V_ACT_X);
    px          = h_cnt;
    py          = v_cnt;
    req         = de_raw;
    line_start  = (h_cnt == '0);
    frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  // Pipeline holds active flags; polarity is applied only at the pin register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        hs_pipe[i] <= 1'b0;
        vs_pipe[i] <= 1'b0;
        de_pipe[i] <= 1'b0;
      end
    end else begin
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= de_raw;
      for (int i = 1; i < PIPE_LAT; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W+2:0] H_ACT_B = (CNT_W+3)'(H_ACTIVE);

  logic [2:0] bar_raw;
  logic [2:0] bar_pipe [PIPE_LAT];
  logic       tp_pipe  [PIPE_LAT];

  assign bar_raw = 3'({h_cnt, 3'b000} / H_ACT_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        bar_pipe[i] <= '0;
        tp_pipe[i]  <= 1'b0;
      end
    end else begin
      bar_pipe[0] <= bar_raw;
      tp_pipe[0]  <= tp_sel;
      for (int i = 1; i < PIPE_LAT; i++) begin
        bar_pipe[i] <= bar_pipe[i-1];
        tp_pipe[i]  <= tp_pipe[i-1];
      end
    end
  end

  always_comb begin
    r_nxt = i_red;
    g_nxt = i_green;
    b_nxt = i_blue;
    if (tp_pipe[PIPE_LAT-1]) begin
      r_nxt = bar_pipe[PIPE_LAT-1][2] ? '1 : '0;
      g_nxt = bar_pipe[PIPE_LAT-1][1] ? '1 : '0;
      b_nxt = bar_pipe[PIPE_LAT-1][0] ? '1 : '0;
    end
  end
`else
  always_comb begin
    r_nxt = i_red;
    g_nxt = i_green;
    b_nxt = i_blue;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_de     <= 1'b0;
      vga_h_sync <= ~HP;
      vga_v_sync <= ~VP;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
    end else begin
      vga_de     <= de_pipe[PIPE_LAT-1];
      vga_h_sync <= hs_pipe[PIPE_LAT-1] ? HP : ~HP;
      vga_v_sync <= vs_pipe[PIPE_LAT-1] ? VP : ~VP;
      vga_r      <= de_pipe[PIPE_LAT-1] ? r_nxt : '0;
      vga_g      <= de_pipe[PIPE_LAT-1] ? g_nxt : '0;
      vga_b      <= de_pipe[PIPE_LAT-1] ? b_nxt : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl_param.sv
// tb/tb_vga_timing_ctrl_param.sv - directed self-checking bench for vga_timing_ctrl_param
module tb_vga_timing_ctrl_param;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 2, HT = HA + HFP + HS + HBP;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1, VT = VA + VFP + VS + VBP;
  localparam int LAT = 2, CW = 5;
  localparam int HA2 = 8, HFP2 = 1, HS2 = 3, HBP2 = 2, HT2 = HA2 + HFP2 + HS2 + HBP2;
  localparam int VA2 = 3, VFP2 = 1, VS2 = 1, VBP2 = 1, VT2 = VA2 + VFP2 + VS2 + VBP2;
  localparam int LAT2 = 1, CW2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] i_red = '0, i_green = '0, i_blue = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic tp_sel = 1'b0;
`endif

  logic [CW-1:0] px, py;
  logic req, frame_start, line_start;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_h_sync, vga_v_sync, vga_de;

  logic [CW2-1:0] px2, py2;
  logic req2, fs2, ls2;
  logic [7:0] r2, g2, b2;
  logic hs2, vs2, de2;

  always #5 clk = ~clk;

  vga_timing_ctrl_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(0), .V_POL(0), .CNT_W(CW), .COLOR_W(8), .PIPE_LAT(LAT)
  ) u_dut (
    .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .px(px), .py(py), .req(req), .frame_start(frame_start), .line_start(line_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .vga_de(vga_de)
  );

  vga_timing_ctrl_param #(
    .H_ACTIVE(HA2), .H_FP(HFP2), .H_SYNC(HS2), .H_BP(HBP2),
    .V_ACTIVE(VA2), .V_FP(VFP2), .V_SYNC(VS2), .V_BP(VBP2),
    .H_POL(1), .V_POL(1), .CNT_W(CW2), .COLOR_W(8), .PIPE_LAT(LAT2)
  ) u_pol (
    .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .tp_sel(1'b0),
`endif
    .i_red(8'hA5), .i_green(8'h3C), .i_blue(8'h5A),
    .px(px2), .py(py2), .req(req2), .frame_start(fs2), .line_start(ls2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .vga_h_sync(hs2), .vga_v_sync(vs2), .vga_de(de2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_req(int k, int ht, int vt, int ha, int va, int cw);
    int h, v;
    h = k % ht;
    v = (k / ht) % vt;
    return 32'((h << (cw + 3)) | (v << 3) | ((h < ha && v < va) ? 4 : 0) |
               ((h == 0 && v == 0) ? 2 : 0) | ((h == 0) ? 1 : 0));
  endfunction

  // mode 0: ramp colours driven by the bench, 1: test pattern, 2: constant A5/3C/5A
  function automatic logic [31:0] exp_pins(int k, int ht, int vt, int ha, int hfp, int hsw,
                                           int va, int vfp, int vsw, int lat, logic pol, int mode);
    int j, h, v, bar;
    logic hs_a, vs_a, de;
    logic [7:0] r, g, b;
    if (k < lat + 1) return 32'({~pol, ~pol, 1'b0, 24'h0});
    j = k - lat - 1;
    h = j % ht;
    v = (j / ht) % vt;
    hs_a = (h >= ha + hfp) && (h < ha + hfp + hsw);
    vs_a = (v >= va + vfp) && (v < va + vfp + vsw);
    de   = (h < ha) && (v < va);
    bar  = (h * 8) / ha;
    case (mode)
      0:       begin r = 8'(h); g = 8'(v); b = 8'(255 - h); end
      1:       begin r = bar[2] ? 8'hFF : 8'h00; g = bar[1] ? 8'hFF : 8'h00; b = bar[0] ? 8'hFF : 8'h00; end
      default: begin r = 8'hA5; g = 8'h3C; b = 8'h5A; end
    endcase
    if (!de) begin r = '0; g = '0; b = '0; end
    return 32'({hs_a ? pol : ~pol, vs_a ? pol : ~pol, de, r, g, b});
  endfunction

  int k;
  int tp_mode = 0;
  int fs_k [2];
  int fs_n, ls_n, ls2_n;
  int ls_k [2];
  int ls2_k [2];
  int hs_fall, hs_low, hs_run, vs_fall, vs_low, vs_run, hs2_high, hs2_run;
  logic hs_prev, vs_prev;

  task automatic reset_track();
    fs_k = '{-1, -1}; ls_k = '{-1, -1}; ls2_k = '{-1, -1};
    fs_n = 0; ls_n = 0; ls2_n = 0;
    hs_fall = -1; hs_low = -1; hs_run = 0;
    vs_fall = -1; vs_low = -1; vs_run = 0;
    hs2_high = -1; hs2_run = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},  32'({px, py, req, frame_start, line_start}), 32'({5'd0, 5'd0, 3'b111}));
    chk({tag, "_pins"}, 32'({vga_h_sync, vga_v_sync, vga_de, vga_r, vga_g, vga_b}), 32'({2'b11, 1'b0, 24'h0}));
    chk({tag, "_pins2"}, 32'({hs2, vs2, de2, r2, g2, b2}), 32'h0);
  endtask

  task automatic step();
    chk($sformatf("req k=%0d", k), 32'({px, py, req, frame_start, line_start}),
        exp_req(k, HT, VT, HA, VA, CW));
    chk($sformatf("pins k=%0d", k), 32'({vga_h_sync, vga_v_sync, vga_de, vga_r, vga_g, vga_b}),
        exp_pins(k, HT, VT, HA, HFP, HS, VA, VFP, VS, LAT, 1'b0, tp_mode));
    chk($sformatf("req2 k=%0d", k), 32'({px2, py2, req2, fs2, ls2}),
        exp_req(k, HT2, VT2, HA2, VA2, CW2));
    chk($sformatf("pins2 k=%0d", k), 32'({hs2, vs2, de2, r2, g2, b2}),
        exp_pins(k, HT2, VT2, HA2, HFP2, HS2, VA2, VFP2, VS2, LAT2, 1'b1, 2));

    if (frame_start && fs_n < 2) begin fs_k[fs_n] = k; fs_n++; end
    if (line_start && ls_n < 2) begin ls_k[ls_n] = k; ls_n++; end
    if (ls2 && ls2_n < 2) begin ls2_k[ls2_n] = k; ls2_n++; end
    if (hs_prev && !vga_h_sync && hs_fall < 0) hs_fall = k;
    if (vs_prev && !vga_v_sync && vs_fall < 0) vs_fall = k;
    if (!vga_h_sync) hs_run++;
    else begin if (hs_run > 0 && hs_low < 0) hs_low = hs_run; hs_run = 0; end
    if (!vga_v_sync) vs_run++;
    else begin if (vs_run > 0 && vs_low < 0) vs_low = vs_run; vs_run = 0; end
    if (hs2) hs2_run++;
    else begin if (hs2_run > 0 && hs2_high < 0) hs2_high = hs2_run; hs2_run = 0; end
    hs_prev = vga_h_sync;
    vs_prev = vga_v_sync;

    if (k >= LAT) begin
      i_red   = 8'((k - LAT) % HT);
      i_green = 8'(((k - LAT) / HT) % VT);
      i_blue  = 8'(255 - ((k - LAT) % HT));
    end
    k++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_track();
    repeat (3) @(negedge clk);
    chk_reset_state("reset");

    rst = 1'b0;
    k = 0;
    #1;
    run(490);
    chk("fs_first",   32'(fs_k[0]), 32'd0);
    chk("fs_period",  32'(fs_k[1] - fs_k[0]), 32'd240);
    chk("ls_period",  32'(ls_k[1] - ls_k[0]), 32'd24);
    chk("hs_fall",    32'(hs_fall), 32'd21);
    chk("hs_low",     32'(hs_low), 32'd4);
    chk("vs_fall",    32'(vs_fall), 32'd171);
    chk("vs_low",     32'(vs_low), 32'd48);
    chk("hs2_high",   32'(hs2_high), 32'd3);
    chk("ls2_period", 32'(ls2_k[1] - ls2_k[0]), 32'd14);

    // Park mid-frame at h=10, v=3 then abort the frame with reset
    for (int n = 0; n < 240 && (k % 240) != 82; n++) step();
    chk("mid_pos", 32'({px, py}), 32'({5'd10, 5'd3}));
    rst = 1'b1;
    #1;
    chk_reset_state("mid_rst0");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_reset_state($sformatf("mid_rst%0d", n + 1));
    end
    rst = 1'b0;
    k = 0;
    reset_track();
    #1;
    run(250);
    chk("mid_fs_first",  32'(fs_k[0]), 32'd0);
    chk("mid_fs_period", 32'(fs_k[1] - fs_k[0]), 32'd240);

`ifdef VGA_TEST_PATTERN_EN
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tp_sel  = 1'b1;
    tp_mode = 1;
    rst = 1'b0;
    k = 0;
    reset_track();
    #1;
    run(60);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
